// File: rtl/vending_controller_multi.sv
// Multi-product vending controller: coin credit, per-item price/stock,
// vend with change, cancel refund and in-service restocking.
//
// state   | meaning
// IDLE    | no credit, waiting for coins or a select
// COLLECT | credit > 0, accepting coins / select / cancel
// VEND    | dispensing the latched item, deducting its price
// CHANGE  | paying out the remaining credit
module vending_controller_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int ITEM_W = 2,
  parameter int PRICE_W = 8,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd25, 8'd10, 8'd15, 8'd20},
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5,
  parameter int MAX_CREDIT = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_type,
  input  logic                 sel_valid,
  input  logic [ITEM_W-1:0]    sel_item,
  input  logic                 cancel,
  input  logic                 restock_valid,
  input  logic [ITEM_W-1:0]    restock_item,
  input  logic [STOCK_W-1:0]   restock_qty,
  output logic                 coin_accept,
  output logic                 coin_reject,
  output logic [PRICE_W-1:0]   credit,
  output logic                 vend_valid,
  output logic [ITEM_W-1:0]    vend_item,
  output logic                 change_valid,
  output logic [PRICE_W-1:0]   change_amt,
  output logic                 err_soldout,
  output logic                 err_funds,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] empty
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [PRICE_W:0]   MAX_C      = (PRICE_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] INIT_S     = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;

  state_t                state, state_nxt;
  logic [ITEM_W-1:0]     item, item_nxt;
  logic [PRICE_W-1:0]    credit_nxt, change_amt_nxt;
  logic [ITEM_W-1:0]     vend_item_nxt;
  logic                  coin_accept_nxt, coin_reject_nxt, vend_valid_nxt;
  logic                  change_valid_nxt, err_soldout_nxt, err_funds_nxt;
  logic                  dec_en;
  logic [STOCK_W-1:0]    stock     [NUM_ITEMS];
  logic [STOCK_W-1:0]    stock_nxt [NUM_ITEMS];
  logic [STOCK_W:0]      stock_sum [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]  empty_nxt;
  logic [PRICE_W:0]      coin_val, credit_sum;
  logic                  coin_ok, sel_in_range;
  logic [PRICE_W-1:0]    sel_price, item_price;
  logic [STOCK_W-1:0]    sel_stock;

  function automatic logic [PRICE_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
    price_of = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (int'(idx) == i) price_of = PRICES[i*PRICE_W +: PRICE_W];
  endfunction

  // Decode coin value and look up price/stock for the selection and latched item
  always_comb begin
    case (coin_type)
      2'b00:   coin_val = (PRICE_W+1)'(5);
      2'b01:   coin_val = (PRICE_W+1)'(10);
      2'b10:   coin_val = (PRICE_W+1)'(20);
      default: coin_val = '0;
    endcase
    credit_sum   = {1'b0, credit} + coin_val;
    coin_ok      = (coin_type != 2'b11) && (credit_sum <= MAX_C);
    sel_in_range = int'(sel_item) < NUM_ITEMS;
    sel_price    = price_of(sel_item);
    item_price   = price_of(item);
    sel_stock    = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (int'(sel_item) == i) sel_stock = stock[i];
  end

  // Next-state and next-output logic; cancel beats select beats coin
  always_comb begin
    state_nxt        = state;
    item_nxt         = item;
    credit_nxt       = credit;
    change_amt_nxt   = change_amt;
    vend_item_nxt    = vend_item;
    coin_accept_nxt  = 1'b0;
    coin_reject_nxt  = 1'b0;
    vend_valid_nxt   = 1'b0;
    change_valid_nxt = 1'b0;
    err_soldout_nxt  = 1'b0;
    err_funds_nxt    = 1'b0;
    dec_en           = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && credit != '0) begin
          state_nxt       = CHANGE;
          coin_reject_nxt = coin_valid;
        end else if (sel_valid) begin
          coin_reject_nxt = coin_valid;
          if (!sel_in_range || sel_stock == '0) begin
            err_soldout_nxt = 1'b1;
          end else if (credit < sel_price) begin
            err_funds_nxt = 1'b1;
          end else begin
            state_nxt = VEND;
            item_nxt  = sel_item;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_nxt      = credit_sum[PRICE_W-1:0];
            coin_accept_nxt = 1'b1;
            state_nxt       = COLLECT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_nxt = coin_valid;
        vend_valid_nxt  = 1'b1;
        vend_item_nxt   = item;
        dec_en          = 1'b1;
        credit_nxt      = credit - item_price;
        state_nxt       = (credit != item_price) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_nxt  = coin_valid;
        change_valid_nxt = 1'b1;
        change_amt_nxt   = credit;
        credit_nxt       = '0;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stock update: restock add and vend decrement combine, then saturate
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_sum[i] = {1'b0, stock[i]};
      if (restock_valid && int'(restock_item) == i)
        stock_sum[i] = stock_sum[i] + {1'b0, restock_qty};
      if (dec_en && int'(item) == i)
        stock_sum[i] = stock_sum[i] - (STOCK_W+1)'(1);
      stock_nxt[i] = (stock_sum[i] > {1'b0, STOCK_MAX}) ? STOCK_MAX : stock_sum[i][STOCK_W-1:0];
      empty_nxt[i] = (stock_nxt[i] == '0);
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      item         <= '0;
      credit       <= '0;
      change_amt   <= '0;
      vend_item    <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      err_soldout  <= 1'b0;
      err_funds    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      item         <= item_nxt;
      credit       <= credit_nxt;
      change_amt   <= change_amt_nxt;
      vend_item    <= vend_item_nxt;
      coin_accept  <= coin_accept_nxt;
      coin_reject  <= coin_reject_nxt;
      vend_valid   <= vend_valid_nxt;
      change_valid <= change_valid_nxt;
      err_soldout  <= err_soldout_nxt;
      err_funds    <= err_funds_nxt;
      busy         <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

  // Per-item stock counters and their empty flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= INIT_S;
        empty[i] <= (INIT_S == '0);
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= stock_nxt[i];
        empty[i] <= empty_nxt[i];
      end
    end
  end

endmodule
